mul_seq: RTL and testbench

Iterative shift-add multiplier, the clocked and parametrised successor to the team's 8-bit combinational signed/unsigned multiplier. It multiplies two WIDTH-bit operands, either unsigned or two's-complement selected per operation, in exactly WIDTH iterations and returns a 2×WIDTH-bit product. It sits in the arithmetic unit, sharing one adder across cycles in place of a full array multiplier, and talks to its controller through a start/ready/done handshake.

---
 rtl/mul_seq.sv | 118 +++++++++++
 tb/tb_mul_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative shift-add multiplier, unsigned or two's-complement, WIDTH iterations
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Signed,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Prod
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CALC = 1'b1;

  logic [0:0]       state;
  // Magnitude of A, shifted left once per iteration so it always sits at bit cnt.
  logic [PW-1:0]    mcand;
  // Magnitude of B, consumed LSB first.
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_in;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    prod_fin;

  assign ready  = (state == S_IDLE);
  assign busy   = (state == S_CALC);
  assign accept = ready & start;
  assign last   = (cnt == CNT_LAST);

  // Operand magnitudes and result sign, evaluated on the accepting edge.
  // The most-negative value maps onto 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mag_a  = (Signed & A[WIDTH-1]) ? (~A + 1'b1) : A;
    mag_b  = (Signed & B[WIDTH-1]) ? (~B + 1'b1) : B;
    neg_in = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
  end

  // One shared adder per iteration, plus the final conditional negation.
  always_comb begin
    addend   = mplier[0] ? mcand : '0;
    acc_sum  = acc + addend;
    prod_fin = neg ? (~acc_sum + 1'b1) : acc_sum;
  end

  // Control state, iteration counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operands captured on accept, accumulated while calculating.
  // Inputs are not looked at again until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      neg    <= neg_in;
    end else if (busy) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Result register: only a completed operation updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Prod <= '0;
    end else if (busy && last) begin
      Prod <= prod_fin;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq at WIDTH 8, 4 and 16
module tb_mul_seq;

  logic clk;
  logic rst_n;

  logic        start8, s8, ready8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  logic        start4, s4, ready4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;

  logic        start16, s16, ready16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

  int total;
  int bad;

  mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Signed(s8),
    .ready(ready8), .busy(busy8), .done(done8), .Prod(prod8)
  );

  mul_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .Signed(s4),
    .ready(ready4), .busy(busy4), .done(done4), .Prod(prod4)
  );

  mul_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16), .Signed(s16),
    .ready(ready16), .busy(busy16), .done(done16), .Prod(prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  vec_t tbl [10];

  // Reference: interpret operands as integers, multiply, wrap to 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input bit s);
    logic signed [63:0] sa, sb, p, m;
    m  = (64'sd1 <<< w) - 64'sd1;
    sa = $signed({32'd0, a}) & m;
    sb = $signed({32'd0, b}) & m;
    if (s && sa[w-1]) sa = sa - (64'sd1 <<< w);
    if (s && sb[w-1]) sb = sb - (64'sd1 <<< w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full WIDTH=8 operation; entered 1 time unit after a clock edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input string nm);
    int n;
    n = 0;
    while (!ready8 && n < 40) begin tick(); n++; end
    a8 = a; b8 = b; s8 = s; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    chk({nm, " busy after accept"}, 64'(busy8), 64'd1);
    n = 0;
    while (!done8 && n < 20) begin tick(); n++; end
    chk({nm, " latency"}, 64'(n), 64'd8);
    chk({nm, " prod"}, 64'(prod8), 64'(exp));
    tick();
    chk({nm, " done one cycle"}, 64'(done8), 64'd0);
  endtask

  // Exhaustive WIDTH=4, start held high so every done cycle is also an accept.
  task automatic stream4();
    int n;
    start4 = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          a4 = 4'(a); b4 = 4'(b); s4 = 1'(s);
          tick();
          n = 0;
          while (!done4 && n < 10) begin tick(); n++; end
          chk($sformatf("w4 s=%0d %0h*%0h cycles", s, a, b), 64'(n), 64'd4);
          chk($sformatf("w4 s=%0d %0h*%0h prod", s, a, b), 64'(prod4),
              ref_prod(4, 32'(a), 32'(b), s[0]));
        end
      end
    end
    start4 = 1'b0;
  endtask

  // Random WIDTH=16, back-to-back in the same way.
  task automatic stream16();
    int n;
    logic [15:0] a, b;
    logic s;
    start16 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = (i >= 1500);
      if (i % 500 == 0) a = 16'h8000;
      if (i % 500 == 1) b = 16'hFFFF;
      a16 = a; b16 = b; s16 = s;
      tick();
      n = 0;
      while (!done16 && n < 24) begin tick(); n++; end
      chk($sformatf("w16 #%0d cycles", i), 64'(n), 64'd16);
      chk($sformatf("w16 #%0d %0h*%0h s=%0d prod", i, a, b, s), 64'(prod16),
          ref_prod(16, 32'(a), 32'(b), s));
    end
    start16 = 1'b0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ndone;
    logic [15:0] seen;
    logic [7:0] ra, rb;
    logic rs;

    total = 0; bad = 0;
    tbl[0] = '{8'hC8, 8'h96, 1'b0, 16'h7530};
    tbl[1] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    tbl[2] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[3] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    tbl[4] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 16'h0000};
    tbl[7] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tbl[8] = '{8'h80, 8'h02, 1'b0, 16'h0100};
    tbl[9] = '{8'h00, 8'hFF, 1'b1, 16'h0000};

    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; s8 = 0;
    start4 = 0; a4 = 0; b4 = 0; s4 = 0;
    start16 = 0; a16 = 0; b16 = 0; s16 = 0;
    #12 rst_n = 1'b1;
    tick();
    chk("reset ready", 64'(ready8), 64'd1);
    chk("reset busy", 64'(busy8), 64'd0);
    chk("reset done", 64'(done8), 64'd0);
    chk("reset prod", 64'(prod8), 64'd0);
    tick();

    for (int i = 0; i < 10; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, $sformatf("vec%0d", i));
    end

    // start pulses and operand toggling while calculating
    a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; start8 = 1'b1;
    tick();
    ndone = 0; seen = '0;
    for (int i = 0; i < 8; i++) begin
      start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      tick();
      if (done8) begin ndone++; seen = prod8; end
    end
    start8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) begin ndone++; seen = prod8; end
    end
    chk("ignored start done count", 64'(ndone), 64'd1);
    chk("ignored start prod", 64'(seen), 64'h03A8);

    // reset in the middle of an operation
    a8 = 8'h55; b8 = 8'h0F; s8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset ready", 64'(ready8), 64'd1);
    chk("midreset busy", 64'(busy8), 64'd0);
    chk("midreset done", 64'(done8), 64'd0);
    chk("midreset prod", 64'(prod8), 64'd0);
    #3 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) ndone++;
    end
    chk("midreset no done", 64'(ndone), 64'd0);
    op8(8'h55, 8'h0F, 1'b0, 16'h04FB, "after reset");

    // random WIDTH=8 against the reference
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      op8(ra, rb, rs, 16'(ref_prod(8, 32'(ra), 32'(rb), rs)), $sformatf("rnd8 #%0d", i));
    end

    fork
      stream4();
      stream16();
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
